comparador_multiciclo: RTL and testbench
========================================

COMPARADOR_MULTICICLO -- requirements
Module: comparador_multiciclo

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits.
REQ-002 Parameter CHUNK, default 8: bits compared per cycle; WIDTH SHALL be an integer multiple of CHUNK; NCHUNK = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  request present on rs1/rs2/signed_mode.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 rs1  input  WIDTH  first operand.
REQ-008 rs2  input  WIDTH  second operand.
REQ-009 signed_mode  input  1  1 = two's-complement compare, 0 = unsigned compare.
REQ-010 out_valid  output  1  comparador_code holds a valid result.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 comparador_code  output  2  01 = equal, 10 = rs1 greater, 00 = rs1 less; 11 never driven.
REQ-013 busy  output  1  high in COMPARE or DONE.

Function
REQ-014 States: IDLE, COMPARE, DONE; encoding free.
REQ-015 IDLE: in_ready=1, out_valid=0; on in_valid=1 at an edge, rs1, rs2 and signed_mode are registered, chunk index set to NCHUNK-1, next state COMPARE.
REQ-016 In COMPARE and DONE, in_ready SHALL be 0; in_valid is ignored and rs1/rs2 may change without effect.
REQ-017 COMPARE: each cycle compares one CHUNK slice of the registered operands, MSB slice first (index NCHUNK-1 down to 0).
REQ-018 Top slice in signed mode: MSB of both slices inverted before an unsigned slice compare; all other slices always compared unsigned.
REQ-019 Slices differ: comparador_code registered as 10 (rs1 slice greater) or 00 (less); next state DONE (early termination).
REQ-020 Slices equal and index = 0: comparador_code registered as 01; next state DONE.
REQ-021 Slices equal and index > 0: index decremented; stay in COMPARE.
REQ-022 Latency: if first differing slice is the k-th compared (k = 1..NCHUNK), out_valid rises k edges after the accepting edge; equal operands take NCHUNK edges.
REQ-023 DONE: out_valid=1; comparador_code held stable until the edge where out_ready=1, then next state IDLE, out_valid=0.
REQ-024 in_valid in the same cycle as the out_ready handshake is not accepted (in_ready=0); earliest acceptance is the following cycle, giving minimum issue interval k+2 cycles.
REQ-025 comparador_code retains its last result while in IDLE and COMPARE; only updated at the COMPARE-to-DONE transition.
REQ-026 NCHUNK = 1 (CHUNK = WIDTH): result after exactly 1 edge; behaviour otherwise identical.

Reset
REQ-027 rst=1 at an edge: state IDLE, comparador_code=00, out_valid=0, busy=0, chunk index=0; in_ready=1 from the following cycle.
REQ-028 rst has priority over all handshakes; rst during COMPARE or DONE aborts the operation, the in-flight result is never presented, and no out_valid pulse follows.

Verification (WIDTH=32, CHUNK=8)
REQ-029 rs1=rs2=0xDEADBEEF, unsigned -> out_valid 4 edges after accept, code 01.
REQ-030 rs1=0x80000000, rs2=0x00000001: unsigned -> code 10 after 1 edge; signed -> code 00 after 1 edge.
REQ-031 rs1=0x12345678, rs2=0x12345679, unsigned -> code 00 after 4 edges; rs1=0xFFFFFFFF, rs2=0xFFFFFFFE signed -> code 10 after 4 edges.
REQ-032 Result 10 pending, out_ready=0 for 5 cycles with in_valid=1 and changing rs1/rs2 -> out_valid=1, code 10 stable, in_ready=0, no new request accepted; out_ready=1 -> IDLE next cycle.
REQ-033 rst=1 on second COMPARE cycle -> next cycle IDLE, in_ready=1, out_valid=0, code 00; no result appears afterward.
REQ-034 Back-to-back requests with out_ready tied 1 and in_valid held 1 -> each accepted on first IDLE cycle; codes match a golden $signed/unsigned model for 10,000 random operand/mode pairs.

Source files
------------

// File: rtl/comparador_multiciclo.sv
// Multi-cycle magnitude comparator: walks the operands one CHUNK slice per cycle,
// MSB slice first, and stops at the first differing slice.
module comparador_multiciclo #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       comparador_code,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0]  TOP_IDX  = IDXW'(NCHUNK - 1);
  localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1) << (CHUNK - 1);

  localparam logic [1:0] CODE_LESS    = 2'b00;
  localparam logic [1:0] CODE_EQUAL   = 2'b01;
  localparam logic [1:0] CODE_GREATER = 2'b10;

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  a_reg, b_reg;
  logic              signed_reg;
  logic [IDXW-1:0]   idx_reg, idx_next;
  logic [1:0]        code_reg, code_next;
  logic              load;

  logic [CHUNK-1:0]  a_cur, b_cur, a_cmp, b_cmp;
  logic              flip_msb;

  // Inverting the sign bit of the top slice turns a two's-complement compare
  // into an unsigned one; lower slices are plain magnitude digits.
  always_comb begin
    a_cur    = a_reg[int'(idx_reg) * CHUNK +: CHUNK];
    b_cur    = b_reg[int'(idx_reg) * CHUNK +: CHUNK];
    flip_msb = signed_reg && (idx_reg == TOP_IDX);
    a_cmp    = flip_msb ? (a_cur ^ MSB_MASK) : a_cur;
    b_cmp    = flip_msb ? (b_cur ^ MSB_MASK) : b_cur;
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    code_next  = code_reg;
    load       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          load       = 1'b1;
          idx_next   = TOP_IDX;
          state_next = COMPARE;
        end
      end
      COMPARE: begin
        if (a_cmp != b_cmp) begin
          code_next  = (a_cmp > b_cmp) ? CODE_GREATER : CODE_LESS;
          state_next = DONE;
        end else if (idx_reg == '0) begin
          code_next  = CODE_EQUAL;
          state_next = DONE;
        end else begin
          idx_next = idx_reg - IDXW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      code_reg   <= CODE_LESS;
      signed_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      code_reg  <= code_next;
      if (load) begin
        signed_reg <= signed_mode;
      end
    end
  end

  // Operand registers need no reset: they are only read after a load.
  always_ff @(posedge clk) begin
    if (load) begin
      a_reg <= rs1;
      b_reg <= rs2;
    end
  end

  assign in_ready        = (state_reg == IDLE);
  assign out_valid       = (state_reg == DONE);
  assign busy            = (state_reg != IDLE);
  assign comparador_code = code_reg;

endmodule

// File: tb/tb_comparador_multiciclo.sv
// Self-checking bench for comparador_multiciclo (WIDTH=32, CHUNK=8): directed
// table, hold/reset corner sequences and randomized back-to-back traffic.
module tb_comparador_multiciclo;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] rs1, rs2;
  logic        signed_mode;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  comparador_code;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  comparador_multiciclo #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .signed_mode(signed_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .comparador_code(comparador_code), .busy(busy)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [1:0]  code;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference: ordinary signed/unsigned comparison of whole operands.
  function automatic logic [1:0] ref_code(input logic [31:0] a, input logic [31:0] b, input logic s);
    if (a == b) return 2'b01;
    if (s) return ($signed(a) > $signed(b)) ? 2'b10 : 2'b00;
    return (a > b) ? 2'b10 : 2'b00;
  endfunction

  // Reference latency: position (from the top) of the first differing byte.
  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b);
    for (int k = 1; k <= 4; k++) begin
      if (a[(4 - k) * 8 +: 8] != b[(4 - k) * 8 +: 8]) return k;
    end
    return 4;
  endfunction

  // Called #1 after a rising edge with the DUT expected idle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input bit hold, output logic [1:0] code, output int lat);
    check("ready_before_accept", in_ready, 1'b1);
    rs1 = a; rs2 = b; signed_mode = s; in_valid = 1'b1;
    @(posedge clk); #1;
    if (hold) begin
      rs1 = $urandom; rs2 = $urandom; signed_mode = 1'($urandom);
    end else begin
      in_valid = 1'b0;
    end
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 20);
    code = comparador_code;
    check("busy_in_done", busy, 1'b1);
    check("ready_low_in_done", in_ready, 1'b0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = hold;
    check("valid_drop_after_hs", out_valid, 1'b0);
    check("ready_after_hs", in_ready, 1'b1);
  endtask

  initial begin
    vec_t        vecs [10];
    logic [1:0]  code;
    int          lat;
    logic [31:0] a, b, topmask;
    logic        s;
    int          m;

    vecs[0] = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 2'b01, 4};
    vecs[1] = '{32'h80000000, 32'h00000001, 1'b0, 2'b10, 1};
    vecs[2] = '{32'h80000000, 32'h00000001, 1'b1, 2'b00, 1};
    vecs[3] = '{32'h12345678, 32'h12345679, 1'b0, 2'b00, 4};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 2'b10, 4};
    vecs[5] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 2'b10, 1};
    vecs[6] = '{32'h7FFFFFFF, 32'h80000000, 1'b0, 2'b00, 1};
    vecs[7] = '{32'h12340000, 32'h12FF0000, 1'b0, 2'b00, 2};
    vecs[8] = '{32'hFFFF0100, 32'hFFFF0200, 1'b1, 2'b00, 3};
    vecs[9] = '{32'h00000000, 32'h00000000, 1'b1, 2'b01, 4};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    rs1 = '0; rs2 = '0; signed_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_code", comparador_code, 2'b00);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, 1'b0, code, lat);
      check("table_code", code, vecs[i].code);
      check("table_latency", lat, vecs[i].lat);
      $display("table %0d: rs1=%h rs2=%h signed=%0d code=%b latency=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].s, code, lat);
    end

    // Result held while consumer stalls and new requests are presented.
    check("hold_ready_idle", in_ready, 1'b1);
    rs1 = 32'h80000000; rs2 = 32'h00000001; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("hold_valid_rise", out_valid, 1'b1);
    for (int c = 0; c < 5; c++) begin
      rs1 = $urandom; rs2 = $urandom; signed_mode = 1'($urandom);
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1'b1);
      check("hold_code", comparador_code, 2'b10);
      check("hold_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hold_release_idle", in_ready, 1'b1);
    check("hold_release_valid", out_valid, 1'b0);
    $display("hold sequence: code=%b held through stall", comparador_code);

    // Reset in the second COMPARE cycle aborts the operation.
    rs1 = 32'hCAFEF00D; rs2 = 32'hCAFEF00D; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", busy, 1'b1);
    check("abort_code_retained", comparador_code, 2'b10);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_code", comparador_code, 2'b00);
    check("abort_busy_low", busy, 1'b0);
    begin
      int pulses = 0;
      repeat (8) begin
        @(posedge clk); #1;
        if (out_valid) pulses++;
      end
      check("abort_no_result", pulses, 0);
    end
    $display("abort sequence: reset during compare, code=%b", comparador_code);

    // Randomized back-to-back traffic: in_valid and out_ready held high.
    out_ready = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom);
      m = $urandom_range(0, 4);
      if (m == 4) b = a;
      else begin
        topmask = ~(32'hFFFFFFFF >> (8 * m));
        b = (a & topmask) | (b & ~topmask);
      end
      run_op(a, b, s, 1'b1, code, lat);
      check("rand_code", code, ref_code(a, b, s));
      check("rand_latency", lat, ref_lat(a, b));
    end
    in_valid = 1'b0; out_ready = 1'b0;
    $display("random: 10000 back-to-back transactions issued");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
